dmem_req_queue: RTL and testbench
=================================

DMEM_REQ_QUEUE -- requirements
Module: dmem_req_queue

Interface
REQ-001 The block SHALL have parameter DEPTH_P, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter MAX_LD_P, default 2, meaning the maximum number of loads outstanding at memory (power of two, >=1).
REQ-003 The block SHALL have parameter ADDR_W_P, default 32, meaning the byte address width.
REQ-004 The block SHALL have parameter DATA_W_P, default 32, meaning the data width (multiple of 8).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and n_reset.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock, rising edge
- n_reset  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request present
- req_ready_o  out  1  queue can accept a request
- req_wen_i  in  1  1 = store, 0 = load
- req_byte_i  in  1  byte_not_word
- req_addr_i  in  ADDR_W_P  byte address
- req_wdata_i  in  DATA_W_P  store data
- mem_valid_o  out  1  request to data memory
- mem_wen_o, mem_byte_o  out  1 each  head entry fields
- mem_addr_o  out  ADDR_W_P  head entry address
- mem_wdata_o  out  DATA_W_P  head entry data
- mem_yumi_i  in  1  memory accepted the head request
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DATA_W_P  memory read word
- mem_ryumi_o  out  1  block consumed the read data
- rsp_valid_o  out  1  load response to core
- rsp_rdata_o  out  DATA_W_P  load result
- rsp_yumi_i  in  1  core consumed the response
- count_o  out  clog2(DEPTH_P)+1  FIFO occupancy
- outst_o  out  clog2(MAX_LD_P)+1  outstanding loads
- err_o  out  1  sticky protocol error

Function
REQ-007 The block SHALL drive req_ready_o = (count_o != DEPTH_P) and SHALL enqueue when req_valid_i and req_ready_o are both high.
REQ-008 The block SHALL allow an enqueue and a dequeue in the same cycle at any occupancy below full, leaving count_o unchanged.
REQ-009 The block SHALL wrap the read and write pointers modulo DEPTH_P.
REQ-010 mem_valid_o SHALL be high when the FIFO is non-empty and either the head entry is a store or outst_o < MAX_LD_P.
REQ-011 The block SHALL dequeue the head entry when mem_valid_o and mem_yumi_i are both high.
REQ-012 mem_yumi_i received while mem_valid_o is low SHALL be ignored.
REQ-013 The block SHALL hold the mem_* fields stable while mem_valid_o is high and mem_yumi_i is low.
REQ-014 On a load dequeue, the block SHALL push {req_byte, addr[1:0]} into a tag FIFO of depth MAX_LD_P and SHALL increment outst_o.
REQ-015 mem_ryumi_o SHALL equal mem_rvalid_i AND (outst_o != 0) AND (rsp_valid_o == 0 OR rsp_yumi_i).
REQ-016 On mem_ryumi_o, the block SHALL pop the tag FIFO, decrement outst_o, and register the response.
- rsp_valid_o rises on the following cycle.
- Word load: rsp_rdata_o = mem_rdata_i.
- Byte load: rsp_rdata_o = the byte at lane addr[1:0], zero-extended, where lane 0 = bits 7:0.
REQ-017 A simultaneous load dequeue and mem_ryumi_o SHALL leave outst_o unchanged.
REQ-018 Load responses SHALL return in issue order.
REQ-019 Stores SHALL produce no response.
REQ-020 mem_rvalid_i received while outst_o == 0 SHALL be ignored: mem_ryumi_o stays 0 and err_o sets.
REQ-021 err_o SHALL clear only on reset.
REQ-022 rsp_valid_o SHALL clear on rsp_yumi_i unless a new response is loaded in the same cycle, in which case it stays high with the new data.
REQ-023 rsp_rdata_o SHALL hold stable while rsp_valid_o is high and rsp_yumi_i is low.

Reset
REQ-024 On n_reset low, the block SHALL immediately clear all pointers, counters, the tag FIFO, the response register and err_o.
REQ-025 During and after reset, outputs SHALL be: req_ready_o 1; mem_valid_o, mem_ryumi_o, rsp_valid_o and err_o 0; count_o and outst_o 0; data outputs 0.
REQ-026 Reset mid-operation SHALL discard queued and outstanding requests, and later mem_rvalid_i SHALL be handled per REQ-020.

Verification
REQ-027 Fill: with DEPTH_P=4 and mem_yumi_i=0, issue 5 back-to-back stores -> 4 accepted, req_ready_o=0 and count_o=4 after the 4th; the 5th is held until mem_yumi_i pulses.
REQ-028 Load throttle: with MAX_LD_P=2, queue 3 loads, hold mem_yumi_i=1 and mem_rvalid_i=0 -> 2 issued, outst_o=2, mem_valid_o=0; one mem_rvalid_i -> the 3rd issues.
REQ-029 Byte extract: LBU at addr 0x...3, mem_rdata_i=0xAABBCCDD -> rsp_rdata_o=0x000000AA one cycle after mem_ryumi_o; LW -> 0xAABBCCDD.
REQ-030 Backpressure: rsp_yumi_i=0 with 2 reads returning -> first held stable, second mem_ryumi_o=0 until rsp_yumi_i; the second appears on the cycle after consumption.
REQ-031 Stray data: mem_rvalid_i=1 with outst_o=0 -> mem_ryumi_o=0, err_o=1 and sticky.
REQ-032 Async reset: assert n_reset mid-stream between clock edges -> outputs take the REQ-025 values without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_req_queue.sv
// Data-memory request queue: buffers core loads/stores, throttles outstanding
// loads, and returns load data (with byte-lane extraction) in issue order.
module dmem_req_queue #(
    parameter int DEPTH_P  = 4,
    parameter int MAX_LD_P = 2,
    parameter int ADDR_W_P = 32,
    parameter int DATA_W_P = 32
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_wen_i,
    input  logic                      req_byte_i,
    input  logic [ADDR_W_P-1:0]       req_addr_i,
    input  logic [DATA_W_P-1:0]       req_wdata_i,
    output logic                      mem_valid_o,
    output logic                      mem_wen_o,
    output logic                      mem_byte_o,
    output logic [ADDR_W_P-1:0]       mem_addr_o,
    output logic [DATA_W_P-1:0]       mem_wdata_o,
    input  logic                      mem_yumi_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_W_P-1:0]       mem_rdata_i,
    output logic                      mem_ryumi_o,
    output logic                      rsp_valid_o,
    output logic [DATA_W_P-1:0]       rsp_rdata_o,
    input  logic                      rsp_yumi_i,
    output logic [$clog2(DEPTH_P):0]  count_o,
    output logic [$clog2(MAX_LD_P):0] outst_o,
    output logic                      err_o
);

    localparam int PW  = $clog2(DEPTH_P);
    localparam int CW  = PW + 1;
    localparam int OW  = $clog2(MAX_LD_P) + 1;
    localparam int TPW = (MAX_LD_P > 1) ? $clog2(MAX_LD_P) : 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH_P);
    localparam logic [OW-1:0]  MAX_LD_C   = OW'(MAX_LD_P);
    localparam logic [TPW-1:0] TAG_LAST_C = TPW'(MAX_LD_P - 1);

    typedef struct packed {
        logic                wen;
        logic                byt;
        logic [ADDR_W_P-1:0] addr;
        logic [DATA_W_P-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic       byt;
        logic [1:0] lane;
    } tag_t;

    req_t                fifo_q [DEPTH_P];
    tag_t                tag_q  [MAX_LD_P];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TPW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W_P-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                err_q, err_d;

    req_t head;
    tag_t rtag;
    logic enq, deq, ld_issue, rd_take;

    assign head     = fifo_q[rd_ptr_q];
    assign rtag     = tag_q[tag_rd_q];
    assign enq      = req_valid_i && req_ready_o;
    assign deq      = mem_valid_o && mem_yumi_i;
    assign ld_issue = deq && !head.wen;
    assign rd_take  = mem_ryumi_o;

    assign req_ready_o = (count_q != DEPTH_C);
    // Loads stall at the head once the tag FIFO is full; stores never wait on it.
    assign mem_valid_o = (count_q != '0) && (head.wen || (outst_q < MAX_LD_C));
    assign mem_wen_o   = head.wen;
    assign mem_byte_o  = head.byt;
    assign mem_addr_o  = head.addr;
    assign mem_wdata_o = head.wdata;
    assign mem_ryumi_o = mem_rvalid_i && (outst_q != '0) && (!rsp_valid_q || rsp_yumi_i);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign count_o     = count_q;
    assign outst_o     = outst_q;
    assign err_o       = err_q;

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;
        outst_d     = outst_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q || (mem_rvalid_i && (outst_q == '0));

        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (ld_issue) tag_wr_d = (tag_wr_q == TAG_LAST_C) ? '0 : tag_wr_q + 1'b1;
        if (rd_take)  tag_rd_d = (tag_rd_q == TAG_LAST_C) ? '0 : tag_rd_q + 1'b1;
        case ({ld_issue, rd_take})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        if (rd_take) begin
            rsp_valid_d = 1'b1;
            if (rtag.byt) begin
                rsp_rdata_d      = '0;
                rsp_rdata_d[7:0] = mem_rdata_i[{rtag.lane, 3'b000} +: 8];
            end else begin
                rsp_rdata_d = mem_rdata_i;
            end
        end else if (rsp_yumi_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            outst_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            outst_q     <= outst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    // NOTE: storage is reset too, so the head fields read as zero after reset instead of X.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH_P; i++)  fifo_q[i] <= '0;
            for (int i = 0; i < MAX_LD_P; i++) tag_q[i]  <= '0;
        end else begin
            if (enq) begin
                fifo_q[wr_ptr_q] <= req_t'{wen: req_wen_i, byt: req_byte_i,
                                           addr: req_addr_i, wdata: req_wdata_i};
            end
            if (ld_issue) tag_q[tag_wr_q] <= tag_t'{byt: head.byt, lane: head.addr[1:0]};
        end
    end

endmodule

// File: tb/tb_dmem_req_queue.sv
// Bench for dmem_req_queue: queue-based reference model plus a response
// scoreboard, driven by directed scenarios and a randomized phase.
module tb_dmem_req_queue;

    localparam int DEPTH  = 4;
    localparam int MAX_LD = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        req_valid_i, req_wen_i, req_byte_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        mem_valid_o, mem_wen_o, mem_byte_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_yumi_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_ryumi_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_yumi_i;
    logic [2:0]  count_o;
    logic [1:0]  outst_o;
    logic        err_o, req_ready_o;

    always #5 clk = ~clk;

    dmem_req_queue #(.DEPTH_P(DEPTH), .MAX_LD_P(MAX_LD), .ADDR_W_P(32), .DATA_W_P(32)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_byte_i(req_byte_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_ryumi_o(mem_ryumi_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_yumi_i(rsp_yumi_i),
        .count_o(count_o), .outst_o(outst_o), .err_o(err_o)
    );

    typedef struct {
        bit          wen;
        bit          byt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_s;

    typedef struct {
        bit       byt;
        bit [1:0] lane;
    } tag_s;

    req_s        m_fifo[$];
    tag_s        m_tags[$];
    logic [31:0] exp_q[$];
    bit          m_rsp_valid;
    bit          m_err;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_tags.delete();
        exp_q.delete();
        m_rsp_valid = 0;
        m_err       = 0;
    endtask

    // Compare every observable output against the model, then advance the model
    // by what the coming clock edge must do given the inputs now applied.
    task automatic eval();
        int   cnt, outst;
        bit   e_ready, e_mval, e_ryumi, enq, deq;
        req_s r;
        tag_s t;
        logic [31:0] data;
        cnt     = m_fifo.size();
        outst   = m_tags.size();
        e_ready = cnt < DEPTH;
        e_mval  = (cnt > 0) && (m_fifo[0].wen || outst < MAX_LD);
        e_ryumi = mem_rvalid_i && outst > 0 && (!m_rsp_valid || rsp_yumi_i);
        check("req_ready", req_ready_o, e_ready);
        check("mem_valid", mem_valid_o, e_mval);
        check("count", count_o, cnt);
        check("outst", outst_o, outst);
        check("mem_ryumi", mem_ryumi_o, e_ryumi);
        check("rsp_valid", rsp_valid_o, m_rsp_valid);
        check("err", err_o, m_err);
        if (e_mval) begin
            check("mem_wen", mem_wen_o, m_fifo[0].wen);
            check("mem_byte", mem_byte_o, m_fifo[0].byt);
            check("mem_addr", mem_addr_o, m_fifo[0].addr);
            check("mem_wdata", mem_wdata_o, m_fifo[0].wdata);
        end
        if (!n_reset) return;
        enq = req_valid_i && e_ready;
        deq = e_mval && mem_yumi_i;
        if (mem_rvalid_i && outst == 0) m_err = 1;
        if (e_ryumi) begin
            t    = m_tags.pop_front();
            data = t.byt ? ((mem_rdata_i >> (8 * t.lane)) & 32'hFF) : mem_rdata_i;
            exp_q.push_back(data);
            m_rsp_valid = 1;
        end else if (rsp_yumi_i) begin
            m_rsp_valid = 0;
        end
        if (deq) begin
            r = m_fifo.pop_front();
            if (!r.wen) m_tags.push_back('{r.byt, r.addr[1:0]});
        end
        if (enq) m_fifo.push_back('{req_wen_i, req_byte_i, req_addr_i, req_wdata_i});
    endtask

    // Inputs are changed at posedge+1; the model check happens at negedge.
    task automatic tick();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit v, input bit wen, input bit byt, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid_i = v;
        req_wen_i   = wen;
        req_byte_i  = byt;
        req_addr_i  = a;
        req_wdata_i = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_mem_valid"}, mem_valid_o, 0);
        check({tag, "_mem_ryumi"}, mem_ryumi_o, 0);
        check({tag, "_rsp_valid"}, rsp_valid_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_count"}, count_o, 0);
        check({tag, "_outst"}, outst_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
    endtask

    // Scoreboard monitor: whenever a response is presented it must match the oldest expected one.
    always @(negedge clk) begin
        if (n_reset && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid_o, 0);
            end else begin
                check("rsp_rdata", rsp_rdata_o, exp_q[0]);
                if (rsp_yumi_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_reset = 1'b0;
        set_req(0, 0, 0, 0, 0);
        mem_yumi_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; rsp_yumi_i = 0;
        model_reset();
        #22;
        check_reset_outputs("por");
        @(posedge clk); #1;
        n_reset = 1'b1;

        // Fill: five back-to-back stores into a four-entry queue with memory stalled.
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1, 0, 32'h100 + 4 * i, 32'h5000 + i);
            tick();
        end
        check("fill_count", count_o, 4);
        check("fill_ready", req_ready_o, 0);
        tick();
        mem_yumi_i = 1; tick();
        mem_yumi_i = 0; tick();
        check("fill_fifth_in", count_o, 4);
        set_req(0, 0, 0, 0, 0);
        mem_yumi_i = 1;
        for (int i = 0; i < 5; i++) tick();
        check("fill_drained", count_o, 0);

        // Load throttle and byte extraction.
        mem_yumi_i = 0;
        set_req(1, 0, 1, 32'h1003, 0); tick();
        set_req(1, 0, 0, 32'h2000, 0); tick();
        set_req(1, 0, 1, 32'h2001, 0); tick();
        set_req(0, 0, 0, 0, 0);
        mem_yumi_i = 1;
        for (int i = 0; i < 3; i++) tick();
        check("thr_outst", outst_o, 2);
        check("thr_mem_valid", mem_valid_o, 0);
        check("thr_count", count_o, 1);
        mem_rvalid_i = 1; mem_rdata_i = 32'hAABBCCDD; tick();
        check("lbu_lane3", rsp_rdata_o, 32'h000000AA);
        check("thr_third_ready", mem_valid_o, 1);
        rsp_yumi_i = 1; tick();
        check("lw_word", rsp_rdata_o, 32'hAABBCCDD);
        check("thr_outst_same", outst_o, 1);
        check("thr_third_issued", count_o, 0);
        mem_rdata_i = 32'h11223344; tick();
        check("lbu_lane1", rsp_rdata_o, 32'h00000033);
        mem_rvalid_i = 0; tick();

        // Response backpressure.
        rsp_yumi_i = 0;
        set_req(1, 0, 0, 32'h3000, 0); tick();
        set_req(1, 0, 0, 32'h3004, 0); tick();
        set_req(0, 0, 0, 0, 0);
        tick(); tick();
        check("bp_outst", outst_o, 2);
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0001; tick();
        mem_rdata_i = 32'hCAFE0002;
        for (int i = 0; i < 3; i++) begin
            check("bp_ryumi_blocked", mem_ryumi_o, 0);
            tick();
            check("bp_hold", rsp_rdata_o, 32'hCAFE0001);
        end
        rsp_yumi_i = 1; tick();
        check("bp_second", rsp_rdata_o, 32'hCAFE0002);
        check("bp_second_valid", rsp_valid_o, 1);
        mem_rvalid_i = 0; tick();
        mem_yumi_i = 0; rsp_yumi_i = 0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            set_req($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom, $urandom);
            mem_yumi_i   = $urandom_range(0, 1);
            mem_rvalid_i = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            rsp_yumi_i   = $urandom_range(0, 99) < 60;
            tick();
        end

        // Drain, then stray read data.
        set_req(0, 0, 0, 0, 0);
        mem_yumi_i = 1; rsp_yumi_i = 1;
        for (int i = 0; i < 30; i++) begin
            mem_rvalid_i = m_tags.size() > 0;
            mem_rdata_i  = $urandom;
            tick();
        end
        check("drain_count", count_o, 0);
        check("drain_outst", outst_o, 0);
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; #1;
        check("stray_ryumi", mem_ryumi_o, 0);
        tick();
        check("stray_err", err_o, 1);
        mem_rvalid_i = 0;
        for (int i = 0; i < 3; i++) tick();
        check("stray_err_sticky", err_o, 1);

        // Asynchronous reset in the middle of traffic.
        mem_yumi_i = 0; rsp_yumi_i = 0;
        set_req(1, 0, 0, 32'h4000, 0); tick();
        set_req(1, 1, 0, 32'h4004, 32'h77); tick();
        set_req(1, 1, 1, 32'h4008, 32'h88); tick();
        set_req(0, 0, 0, 0, 0);
        mem_yumi_i = 1; tick();
        mem_yumi_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5A5A5A5A; tick();
        mem_rvalid_i = 0;
        check("pre_rst_rsp", rsp_valid_o, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        tick();
        n_reset = 1'b1;
        mem_rvalid_i = 1; mem_rdata_i = 32'h12345678; #1;
        check("post_rst_ryumi", mem_ryumi_o, 0);
        tick();
        check("post_rst_err", err_o, 1);
        mem_rvalid_i = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
